// File: rtl/surfboard_loader_if.sv
// Handshake bundle for surfboard_loader: element stream in, packed A/B operand frame out.
// The slave modport is the loader's view; the master modport is the surrounding environment.
interface surfboard_loader_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] A [0:3];
  logic [W-1:0] B [0:3];

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, A, B
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, A, B
  );
endinterface

// File: rtl/surfboard_loader.sv
// surfboard_loader: packs 8-element frames into operands A/B and presents them under valid/ready.
// Define SURFBOARD_LOADER_PINGPONG_EN for a second bank so the next frame loads during presentation.
module surfboard_loader #(
  parameter int W         = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  surfboard_loader_if.slave    bus,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

`ifdef SURFBOARD_LOADER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic {EMPTY, FULL} bank_state_t;

  bank_state_t  bank_st      [NB];
  bank_state_t  bank_st_next [NB];
  logic [W-1:0] bank_mem     [NB][8];
  logic [W-1:0] frame        [8];
  logic [W-1:0] out_frame    [8];
  logic [2:0]   idx;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         rd_ptr_next;
  logic         accept;
  logic         at_end;
  logic         complete;
  logic         drop;
  logic         xfer;

  assign bus.in_ready  = (bank_st[wr_ptr] == EMPTY);
  assign bus.out_valid = (bank_st[rd_ptr] == FULL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign at_end        = (idx == 3'd7);
  assign complete      = accept && bus.in_last && at_end;
  assign drop          = accept && (bus.in_last != at_end);
  assign xfer          = bus.out_valid && bus.out_ready;

`ifdef SURFBOARD_LOADER_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr ^ complete;
      rd_ptr <= rd_ptr_next;
    end
  end

  assign rd_ptr_next = rd_ptr ^ xfer;
`else
  assign wr_ptr      = 1'b0;
  assign rd_ptr      = 1'b0;
  assign rd_ptr_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) bank_st[b] <= EMPTY;
    end else begin
      for (int b = 0; b < NB; b++) bank_st[b] <= bank_st_next[b];
    end
  end

  // Completion and transfer never target the same bank: the write bank is EMPTY, the read bank FULL.
  always_comb begin
    for (int b = 0; b < NB; b++) bank_st_next[b] = bank_st[b];
    if (complete) bank_st_next[wr_ptr] = FULL;
    if (xfer)     bank_st_next[rd_ptr] = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (accept) bank_mem[wr_ptr][idx] <= bus.in_data;
  end

  // Contents the read bank will hold after this edge, bypassing the element landing right now.
  always_comb begin
    for (int i = 0; i < 8; i++) frame[i] = bank_mem[rd_ptr_next][i];
    if (complete && (wr_ptr == rd_ptr_next)) frame[7] = bus.in_data;
  end

  // A separate output copy keeps A/B frozen once a bank is freed and refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) out_frame[i] <= '0;
    end else if (bank_st_next[rd_ptr_next] == FULL) begin
      for (int i = 0; i < 8; i++) out_frame[i] <= frame[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.A[i] = out_frame[i];
      bus.B[i] = out_frame[i+4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 3'd0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= drop;
      if (accept) idx <= (bus.in_last || at_end) ? 3'd0 : idx + 3'd1;
      if (drop && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
